// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between pipeline control and the ALU execute stage.
// master = pipeline side, slave = execute stage.
interface alu_seq_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  result_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output result_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_seq_exec.sv
// ALU execute stage: single-cycle logic/arith ops, iterative 1-bit/cycle shifter.
// state | meaning
// IDLE  | ready; accepts start, single-cycle ops complete here
// SHIFT | shifting work register, counter counts down to 0
module alu_seq_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic         clk,
  input  logic         reset,
  alu_seq_exec_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_LUI = 4'd7;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  r_work;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [SHAMT_WIDTH-1:0] r_cnt;
  logic                   r_dir_left;
  logic                   r_zero;
  logic                   r_done;

  logic [DATA_WIDTH-1:0]  w_single;
  logic [DATA_WIDTH-1:0]  w_work_shifted;
  logic [DATA_WIDTH-1:0]  w_result_nxt;
  logic [SHAMT_WIDTH-1:0] w_shamt;
  logic                   w_accept;
  logic                   w_is_shift;
  logic                   w_start_shift;
  logic                   w_load_result;

  assign w_shamt        = bus.B_i[SHAMT_WIDTH-1:0];
  assign w_accept       = bus.start_i && (r_state == IDLE);
  assign w_is_shift     = (bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL);
  assign w_work_shifted = r_dir_left ? (r_work << 1) : (r_work >> 1);

  // Shift ops only reach this path with shamt=0, where the result is A unchanged.
  always_comb begin
    w_single = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:         w_single = bus.A_i + bus.B_i;
      OP_SUB:         w_single = bus.A_i - bus.B_i;
      OP_XOR:         w_single = bus.A_i ^ bus.B_i;
      OP_OR:          w_single = bus.A_i | bus.B_i;
      OP_AND:         w_single = bus.A_i & bus.B_i;
      OP_SLL, OP_SRL: w_single = bus.A_i;
      OP_LUI:         w_single = bus.B_i;
      default:        w_single = '0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_shift = 1'b0;
    w_load_result = 1'b0;
    w_result_nxt  = w_single;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_shift && (w_shamt != '0)) begin
            w_start_shift = 1'b1;
            w_state_nxt   = SHIFT;
          end else begin
            w_load_result = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (r_cnt == SHAMT_WIDTH'(1)) begin
          w_load_result = 1'b1;
          w_result_nxt  = w_work_shifted;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_dir_left <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_load_result;
      if (w_start_shift) begin
        r_work     <= bus.A_i;
        r_cnt      <= w_shamt;
        r_dir_left <= (bus.ALU_Operation_i == OP_SLL);
      end else if (r_state == SHIFT) begin
        r_work <= w_work_shifted;
        r_cnt  <= r_cnt - SHAMT_WIDTH'(1);
      end
      if (w_load_result) begin
        r_result <= w_result_nxt;
        r_zero   <= (w_result_nxt == '0);
      end
    end
  end

  assign bus.result_o = r_result;
  assign bus.zero_o   = r_zero;
  assign bus.busy_o   = (r_state == SHIFT);
  assign bus.done_o   = r_done;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: scoreboard of expected {zero, result}
// pushed at issue and popped at done_o.
module tb_alu_seq_exec;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] sb_q[$];
  logic [31:0] last_res;

  always #5 clk = ~clk;

  alu_seq_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_seq_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a ^ b;
      4'd3: return a | b;
      4'd4: return a & b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [32:0] sb_entry(input logic [31:0] r);
    return {(r == 32'h0), r};
  endfunction

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = s;
    bus.ALU_Operation_i = op;
    bus.A_i = a;
    bus.B_i = b;
  endtask

  task automatic test_reset();
    logic [32:0] e;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", bus.zero_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    // Reset wins over a start in the same cycle
    drive(1'b1, 4'd0, 32'd5, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_over_start_done got=%b exp=0", bus.done_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL reset_over_start_result got=%h exp=0", bus.result_o); end
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_over_start_late_done got=%b exp=0", bus.done_o); end
    last_res = 32'h0;
    e = 33'h0;
    sb_q.delete();
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops[8] = '{4'd0, 4'd1, 4'd1, 4'd5, 4'd9, 4'd6, 4'd15, 4'd7};
    logic [31:0] as[8]  = '{32'h5, 32'h7, 32'h0, 32'hA5A5_0001, 32'h1234, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] bs[8]  = '{32'h3, 32'h7, 32'h1, 32'h0, 32'h5678, 32'h20, 32'h1, 32'hFFFF_FFFF};
    logic [32:0] e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, ops[i], as[i], bs[i]);
      sb_q.push_back(sb_entry(model(ops[i], as[i], bs[i])));
      @(negedge clk);
      drive(1'b0, 4'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL single_done[%0d] got=%b exp=1", i, bus.done_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy[%0d] got=%b exp=0", i, bus.busy_o); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL single_result[%0d] got=%h exp=%h", i, bus.result_o, e[31:0]); end
        checks++; if (bus.zero_o !== e[32]) begin errors++; $display("FAIL single_zero[%0d] got=%b exp=%b", i, bus.zero_o, e[32]); end
        last_res = e[31:0];
      end
      @(negedge clk);
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL single_done_pulse[%0d] got=%b exp=0", i, bus.done_o); end
      checks++; if (bus.result_o !== last_res) begin errors++; $display("FAIL single_hold[%0d] got=%h exp=%h", i, bus.result_o, last_res); end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ops[4] = '{4'd5, 4'd6, 4'd5, 4'd6};
    logic [31:0] as[4]  = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] bs[4]  = '{32'h4, 32'd31, 32'hFFFF_FFFF, 32'h1};
    logic [32:0] e;
    int lat, busy_cnt, n;
    bit held;
    for (int i = 0; i < 4; i++) begin
      n = int'(bs[i][4:0]);
      @(negedge clk);
      drive(1'b1, ops[i], as[i], bs[i]);
      sb_q.push_back(sb_entry(model(ops[i], as[i], bs[i])));
      @(negedge clk);
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      lat = 1; busy_cnt = 0; held = 1'b1;
      while (bus.done_o !== 1'b1 && lat < 40) begin
        if (bus.busy_o === 1'b1) busy_cnt++;
        if (bus.result_o !== last_res) held = 1'b0;
        @(negedge clk);
        lat++;
      end
      checks++; if (lat != n + 1) begin errors++; $display("FAIL shift_latency[%0d] got=%0d exp=%0d", i, lat, n + 1); end
      checks++; if (busy_cnt != n) begin errors++; $display("FAIL shift_busy_cycles[%0d] got=%0d exp=%0d", i, busy_cnt, n); end
      checks++; if (!held) begin errors++; $display("FAIL shift_result_hold[%0d] got=changed exp=%h", i, last_res); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL shift_busy_at_done[%0d] got=%b exp=0", i, bus.busy_o); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL shift_result[%0d] got=%h exp=%h", i, bus.result_o, e[31:0]); end
        checks++; if (bus.zero_o !== e[32]) begin errors++; $display("FAIL shift_zero[%0d] got=%b exp=%b", i, bus.zero_o, e[32]); end
        last_res = e[31:0];
      end
      @(negedge clk);
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL shift_done_pulse[%0d] got=%b exp=0", i, bus.done_o); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [32:0] e;
    int dones;
    @(negedge clk);
    drive(1'b1, 4'd6, 32'hF0, 32'h3);
    sb_q.push_back(sb_entry(model(4'd6, 32'hF0, 32'h3)));
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL ignore_busy_set got=%b exp=1", bus.busy_o); end
    drive(1'b1, 4'd0, 32'h1, 32'h1);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.done_o === 1'b1) begin
        dones++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL ignore_result got=%h exp=%h", bus.result_o, e[31:0]); end
          last_res = e[31:0];
        end
      end
      @(negedge clk);
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (bus.result_o !== 32'h1E) begin errors++; $display("FAIL ignore_final got=%h exp=0000001e", bus.result_o); end
  endtask

  task automatic test_reset_mid_shift();
    int dones;
    @(negedge clk);
    drive(1'b1, 4'd5, 32'h1, 32'd20);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", bus.busy_o); end
    checks++; if (bus.result_o !== 32'h0) begin errors++; $display("FAIL midreset_result got=%h exp=0", bus.result_o); end
    checks++; if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL midreset_zero got=%b exp=1", bus.zero_o); end
    dones = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.done_o === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", dones); end
    last_res = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[4] = '{4'd2, 4'd3, 4'd7, 4'd4};
    logic [31:0] as[4]  = '{32'hFF, 32'hF0, 32'h0, 32'hFF};
    logic [31:0] bs[4]  = '{32'h0F, 32'h0F, 32'h1234_5000, 32'h0F};
    logic [32:0] e;
    int lat;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d] got=%b exp=1", i - 1, bus.done_o); end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i - 1, bus.result_o, e[31:0]); end
        end
      end
      if (i < 4) begin
        drive(1'b1, ops[i], as[i], bs[i]);
        sb_q.push_back(sb_entry(model(ops[i], as[i], bs[i])));
      end else begin
        drive(1'b0, 4'd0, 32'h0, 32'h0);
      end
    end
    // Issue in the same cycle a shift completes
    @(negedge clk);
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_end got=%b exp=0", bus.done_o); end
    drive(1'b1, 4'd5, 32'h1, 32'h2);
    sb_q.push_back(sb_entry(model(4'd5, 32'h1, 32'h2)));
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    lat = 1;
    while (bus.done_o !== 1'b1 && lat < 10) begin @(negedge clk); lat++; end
    checks++; if (lat != 3) begin errors++; $display("FAIL b2b_shift_latency got=%0d exp=3", lat); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL b2b_shift_result got=%h exp=%h", bus.result_o, e[31:0]); end
    end
    drive(1'b1, 4'd0, 32'h2, 32'h3);
    sb_q.push_back(sb_entry(model(4'd0, 32'h2, 32'h3)));
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL b2b_after_shift_done got=%b exp=1", bus.done_o); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; if (bus.result_o !== e[31:0]) begin errors++; $display("FAIL b2b_after_shift_result got=%h exp=%h", bus.result_o, e[31:0]); end
    end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    drive(1'b0, 4'd0, 32'h0, 32'h0);
    last_res = 32'h0;
    test_reset();
    test_single_cycle();
    test_shift();
    test_ignore_busy();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
